// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus constants: source indices, default widths and a clog2 helper.
package cpu_bus_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned BUS_N = 24;

    localparam int unsigned SRC_R0     = 0;
    localparam int unsigned SRC_R1     = 1;
    localparam int unsigned SRC_R2     = 2;
    localparam int unsigned SRC_R3     = 3;
    localparam int unsigned SRC_R4     = 4;
    localparam int unsigned SRC_R5     = 5;
    localparam int unsigned SRC_R6     = 6;
    localparam int unsigned SRC_R7     = 7;
    localparam int unsigned SRC_R8     = 8;
    localparam int unsigned SRC_R9     = 9;
    localparam int unsigned SRC_R10    = 10;
    localparam int unsigned SRC_R11    = 11;
    localparam int unsigned SRC_R12    = 12;
    localparam int unsigned SRC_R13    = 13;
    localparam int unsigned SRC_R14    = 14;
    localparam int unsigned SRC_R15    = 15;
    localparam int unsigned SRC_HI     = 16;
    localparam int unsigned SRC_LO     = 17;
    localparam int unsigned SRC_ZHI    = 18;
    localparam int unsigned SRC_ZLO    = 19;
    localparam int unsigned SRC_PC     = 20;
    localparam int unsigned SRC_MDR    = 21;
    localparam int unsigned SRC_INPORT = 22;
    localparam int unsigned SRC_C      = 23;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        if (v > 1) begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (((v - 1) >> i) != 0) r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_prio_encoder.sv
// Lowest-index-wins priority encoder over the source-enable strobes.
module bus_prio_encoder
    import cpu_bus_pkg::*;
#(
    parameter int unsigned N = BUS_N,
    localparam int unsigned SELW = (clog2(N) > 0) ? clog2(N) : 1
) (
    input  logic [N-1:0]    src_out,
    output logic            any,
    output logic [SELW-1:0] win,
    output logic            multi
);

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        win = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (src_out[i]) win = SELW'(i);
        end
        any   = |src_out;
        // More than one bit set iff clearing the lowest set bit leaves something.
        multi = |(src_out & (src_out - N'(1)));
    end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered CPU bus multiplexer with selected index and conflict tracking.
module bus_mux_reg
    import cpu_bus_pkg::*;
#(
    parameter int unsigned N         = BUS_N,
    parameter int unsigned W         = BUS_W,
    parameter bit          HOLD_IDLE = 1'b1,
    parameter int unsigned CNTW      = 8,
    localparam int unsigned SELW     = (clog2(N) > 0) ? clog2(N) : 1
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [N-1:0]    src_out,
    input  logic [N*W-1:0]  src_data,
    input  logic            err_clr,
    output logic [W-1:0]    bus_out,
    output logic            bus_valid,
    output logic [SELW-1:0] bus_sel,
    output logic            conflict,
    output logic            conflict_sticky,
    output logic [CNTW-1:0] conflict_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic            any;
    logic [SELW-1:0] win;
    logic            multi;
    logic [W-1:0]    sel_data;
    logic [CNTW-1:0] cnt_base;
    logic [CNTW-1:0] cnt_next;

    bus_prio_encoder #(.N(N)) u_enc (
        .src_out (src_out),
        .any     (any),
        .win     (win),
        .multi   (multi)
    );

    // Pick the winning source word; other sources never reach the output.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win == SELW'(i)) sel_data = src_data[i*W +: W];
        end
    end

    // Clear first, then apply a same-cycle conflict with saturation.
    always_comb begin
        cnt_base = err_clr ? '0 : conflict_cnt;
        cnt_next = cnt_base;
        if (multi && (cnt_base != CNT_MAX)) cnt_next = cnt_base + CNTW'(1);
    end

    // Bus data, index and valid registers with the idle policy.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            bus_out   <= '0;
            bus_sel   <= '0;
            bus_valid <= 1'b0;
        end else if (any) begin
            bus_out   <= sel_data;
            bus_sel   <= win;
            bus_valid <= 1'b1;
        end else begin
            bus_valid <= 1'b0;
            if (!HOLD_IDLE) begin
                bus_out <= '0;
                bus_sel <= '0;
            end
        end
    end

    // Conflict pulse, sticky flag and saturating counter.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end else begin
            conflict     <= multi;
            conflict_cnt <= cnt_next;
            if (multi)        conflict_sticky <= 1'b1;
            else if (err_clr) conflict_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Randomized bench for bus_mux_reg: three configurations against a reference model.
module tb_bus_mux_reg;

    localparam int N  = 24;
    localparam int W  = 32;
    localparam int NI = 3;   // 0: default, 1: HOLD_IDLE=0, 2: CNTW=4

    logic             clock;
    logic             clear;
    logic [N-1:0]     src_out;
    logic [N*W-1:0]   src_data;
    logic             err_clr;

    logic [W-1:0] bus0, bus1, bus2;
    logic         val0, val1, val2;
    logic [4:0]   sel0, sel1, sel2;
    logic         cf0, cf1, cf2;
    logic         st0, st1, st2;
    logic [7:0]   cnt0, cnt1;
    logic [3:0]   cnt2;

    bus_mux_reg dut (
        .clock(clock), .clear(clear), .src_out(src_out), .src_data(src_data), .err_clr(err_clr),
        .bus_out(bus0), .bus_valid(val0), .bus_sel(sel0), .conflict(cf0),
        .conflict_sticky(st0), .conflict_cnt(cnt0)
    );

    bus_mux_reg #(.HOLD_IDLE(1'b0)) dut_h0 (
        .clock(clock), .clear(clear), .src_out(src_out), .src_data(src_data), .err_clr(err_clr),
        .bus_out(bus1), .bus_valid(val1), .bus_sel(sel1), .conflict(cf1),
        .conflict_sticky(st1), .conflict_cnt(cnt1)
    );

    bus_mux_reg #(.CNTW(4)) dut_c4 (
        .clock(clock), .clear(clear), .src_out(src_out), .src_data(src_data), .err_clr(err_clr),
        .bus_out(bus2), .bus_valid(val2), .bus_sel(sel2), .conflict(cf2),
        .conflict_sticky(st2), .conflict_cnt(cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state per configuration.
    int unsigned m_bus   [NI];
    int          m_sel   [NI];
    int          m_valid [NI];
    int          m_conf  [NI];
    int          m_sticky[NI];
    int          m_cnt   [NI];
    int          m_hold  [NI] = '{1, 0, 1};
    int          m_cmax  [NI] = '{255, 255, 15};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_bus[k] = 0; m_sel[k] = 0; m_valid[k] = 0;
            m_conf[k] = 0; m_sticky[k] = 0; m_cnt[k] = 0;
        end
    endtask

    // One clock of the behavioural model, from the current inputs.
    task automatic model_step();
        int nset;
        int first;
        nset  = $countones(src_out);
        first = -1;
        for (int i = 0; i < N; i++) if (src_out[i] && first < 0) first = i;
        for (int k = 0; k < NI; k++) begin
            if (nset > 0) begin
                m_bus[k]   = src_data[first*W +: W];
                m_sel[k]   = first;
                m_valid[k] = 1;
            end else begin
                m_valid[k] = 0;
                if (m_hold[k] == 0) begin
                    m_bus[k] = 0;
                    m_sel[k] = 0;
                end
            end
            m_conf[k] = (nset > 1) ? 1 : 0;
            if (err_clr) begin
                m_cnt[k]    = 0;
                m_sticky[k] = 0;
            end
            if (nset > 1) begin
                m_sticky[k] = 1;
                if (m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic check_inst(input int k, input logic [W-1:0] b, input logic v, input logic [4:0] s,
                              input logic c, input logic st, input logic [7:0] cn);
        check($sformatf("bus_out[%0d]", k),  b,        32'(m_bus[k]));
        check($sformatf("bus_valid[%0d]", k), 32'(v),  32'(m_valid[k]));
        check($sformatf("bus_sel[%0d]", k),  32'(s),   32'(m_sel[k]));
        check($sformatf("conflict[%0d]", k), 32'(c),   32'(m_conf[k]));
        check($sformatf("sticky[%0d]", k),   32'(st),  32'(m_sticky[k]));
        check($sformatf("cnt[%0d]", k),      32'(cn),  32'(m_cnt[k]));
    endtask

    task automatic check_all();
        check_inst(0, bus0, val0, sel0, cf0, st0, cnt0);
        check_inst(1, bus1, val1, sel1, cf1, st1, cnt1);
        check_inst(2, bus2, val2, sel2, cf2, st2, {4'b0, cnt2});
    endtask

    // Advance one edge with model update, then sample 1 time unit later.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic drive(input logic [N-1:0] s, input logic ec);
        for (int i = 0; i < N; i++) src_data[i*W +: W] = $urandom;
        src_out = s;
        err_clr = ec;
    endtask

    initial begin
        logic [N-1:0] r;
        clear    = 1'b0;
        src_out  = '0;
        src_data = '0;
        err_clr  = 1'b0;
        model_reset();
        #3;
        check_all();
        @(negedge clock);
        clear = 1'b1;

        // Reset mid-operation.
        drive(N'(1) << 3, 1'b0);
        src_data[3*W +: W] = 32'hDEADBEEF;
        tick();
        tick();
        #2 clear = 1'b0;
        model_reset();
        #1 check_all();
        check("reset_bus_direct", bus0, 32'h0);
        clear = 1'b1;
        tick();
        check("post_reset_bus", bus0, 32'hDEADBEEF);
        check("post_reset_sel", 32'(sel0), 32'd3);

        // Single-source sweep, back to back.
        for (int i = 0; i < N; i++) begin
            drive(N'(1) << i, 1'b0);
            src_data[i*W +: W] = 32'h1000_0000 + 32'(i);
            tick();
            check("sweep_bus", bus0, 32'h1000_0000 + 32'(i));
        end

        // Conflict priority.
        drive((N'(1) << 5) | (N'(1) << 20), 1'b0);
        src_data[5*W +: W]  = 32'h55;
        src_data[20*W +: W] = 32'hAA;
        tick();
        check("prio_bus", bus0, 32'h55);
        check("prio_cnt", 32'(cnt0), 32'd1);

        // Idle policy.
        drive(N'(1) << 7, 1'b0);
        src_data[7*W +: W] = 32'h1234;
        tick();
        drive('0, 1'b0);
        tick();
        check("hold_bus", bus0, 32'h1234);
        check("nohold_bus", bus1, 32'h0);

        // Counter saturation and clear.
        for (int j = 0; j < 20; j++) begin
            drive(N'($urandom) | N'(3), 1'b0);
            tick();
        end
        check("sat_cnt4", 32'(cnt2), 32'd15);
        drive(N'(1) << 2, 1'b1);
        tick();
        check("clr_cnt4", 32'(cnt2), 32'd0);
        drive(N'(1) << 9 | N'(1) << 11, 1'b1);
        tick();
        check("clr_conf_cnt4", 32'(cnt2), 32'd1);
        check("clr_conf_sticky", 32'(st2), 32'd1);

        // Randomized traffic.
        for (int j = 0; j < 400; j++) begin
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = N'(1) << $urandom_range(0, N - 1);
                2:       r = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
                default: r = N'($urandom);
            endcase
            drive(r, ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
